byte_word_packer_credit: RTL and testbench



---
 rtl/byte_word_packer_credit.sv | 150 +++++++++++++++
 tb/tb_byte_word_packer_credit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer_credit.sv
// Packs IN_WIDTH beats into OUT_WIDTH words for an overwrite FIFO, gating each
// write pulse on a credit that mirrors the free FIFO entries.
module byte_word_packer_credit #(
    parameter int unsigned IN_WIDTH     = 8,
    parameter int unsigned OUT_WIDTH    = 32,
    parameter int unsigned CREDIT_NUM   = 4,
    parameter int unsigned CREDIT_WIDTH = $clog2(CREDIT_NUM + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_vld,
    input  logic [IN_WIDTH-1:0]               in_data,
    input  logic                              in_last,
    output logic                              in_rdy,
    output logic                              out_vld,
    output logic [OUT_WIDTH-1:0]              out_data,
    output logic [OUT_WIDTH/IN_WIDTH-1:0]     out_keep,
    input  logic                              credit_ret,
    output logic [CREDIT_WIDTH-1:0]           credit_cnt,
    output logic                              cred_err
);

    localparam int unsigned NLANE  = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned LANE_W = (NLANE > 1) ? $clog2(NLANE) : 1;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]              state, state_nxt;
    logic [LANE_W-1:0]       lane_idx, lane_nxt;
    logic [OUT_WIDTH-1:0]    acc, acc_nxt;
    logic [NLANE-1:0]        acc_keep, keep_nxt;
    logic                    in_rdy_nxt;
    logic                    out_vld_nxt;
    logic [OUT_WIDTH-1:0]    out_data_nxt;
    logic [NLANE-1:0]        out_keep_nxt;
    logic [CREDIT_WIDTH-1:0] cnt_nxt;
    logic                    err_nxt;

    logic                    accept;
    logic                    credit_avail;
    logic                    completing;
    logic                    consume;
    logic [OUT_WIDTH-1:0]    merged_data;
    logic [NLANE-1:0]        merged_keep;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FILL;
            lane_idx   <= '0;
            acc        <= '0;
            acc_keep   <= '0;
            in_rdy     <= 1'b1;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            credit_cnt <= CREDIT_WIDTH'(CREDIT_NUM);
            cred_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            lane_idx   <= lane_nxt;
            acc        <= acc_nxt;
            acc_keep   <= keep_nxt;
            in_rdy     <= in_rdy_nxt;
            out_vld    <= out_vld_nxt;
            out_data   <= out_data_nxt;
            out_keep   <= out_keep_nxt;
            credit_cnt <= cnt_nxt;
            cred_err   <= err_nxt;
        end
    end

    // Next-state, packing and credit logic
    always_comb begin
        state_nxt    = state;
        lane_nxt     = lane_idx;
        acc_nxt      = acc;
        keep_nxt     = acc_keep;
        out_vld_nxt  = 1'b0;
        out_data_nxt = out_data;
        out_keep_nxt = out_keep;
        consume      = 1'b0;
        cnt_nxt      = credit_cnt;
        err_nxt      = cred_err;

        accept       = in_vld & in_rdy;
        credit_avail = (credit_cnt != '0) | credit_ret;
        completing   = (lane_idx == LANE_W'(NLANE - 1)) | in_last;

        // Current beat merged into the accumulator at its lane
        merged_data = acc;
        merged_data[lane_idx*IN_WIDTH +: IN_WIDTH] = in_data;
        merged_keep = acc_keep;
        merged_keep[lane_idx] = 1'b1;

        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (completing) begin
                        if (credit_avail) begin
                            out_vld_nxt  = 1'b1;
                            out_data_nxt = merged_data;
                            out_keep_nxt = merged_keep;
                            acc_nxt      = '0;
                            keep_nxt     = '0;
                            lane_nxt     = '0;
                            consume      = 1'b1;
                        end else begin
                            acc_nxt   = merged_data;
                            keep_nxt  = merged_keep;
                            state_nxt = ST_WAIT;
                        end
                    end else begin
                        acc_nxt  = merged_data;
                        keep_nxt = merged_keep;
                        lane_nxt = lane_idx + LANE_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (credit_avail) begin
                    out_vld_nxt  = 1'b1;
                    out_data_nxt = acc;
                    out_keep_nxt = acc_keep;
                    acc_nxt      = '0;
                    keep_nxt     = '0;
                    lane_nxt     = '0;
                    consume      = 1'b1;
                    state_nxt    = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase

        in_rdy_nxt = (state_nxt == ST_FILL);

        // A return while already full saturates and flags the mismatch
        if (consume && !credit_ret) begin
            cnt_nxt = credit_cnt - CREDIT_WIDTH'(1);
        end else if (credit_ret && !consume) begin
            if (credit_cnt == CREDIT_WIDTH'(CREDIT_NUM)) begin
                err_nxt = 1'b1;
            end else begin
                cnt_nxt = credit_cnt + CREDIT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_byte_word_packer_credit.sv
// Directed bench for byte_word_packer_credit: stimulus pushes expected words to
// a scoreboard queue, a negedge monitor pops and compares on every out_vld.
module tb_byte_word_packer_credit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_rdy;
    logic        out_vld;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        credit_ret;
    logic [2:0]  credit_cnt;
    logic        cred_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    byte_word_packer_credit dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_rdy     (in_rdy),
        .out_vld    (out_vld),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .credit_ret (credit_ret),
        .credit_cnt (credit_cnt),
        .cred_err   (cred_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on negedge; values read afterwards reflect the previous step
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
        @(negedge clk);
        in_vld     = v;
        in_data    = d;
        in_last    = l;
        credit_ret = r;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k);
        exp_t e;
        e.data = d;
        e.keep = k;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_vld = 1'b0; in_data = 8'h00; in_last = 1'b0; credit_ret = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_credit", 32'(credit_cnt), 32'd4);
        chk("rst_cred_err", 32'(cred_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word: got data=0x%08h keep=0x%0h with no word expected", out_data, out_keep);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_data !== e.data || out_keep !== e.keep) begin
                    failures++;
                    $display("FAIL word: got data=0x%08h keep=0x%0h expected data=0x%08h keep=0x%0h",
                             out_data, out_keep, e.data, e.keep);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_vld = 1'b0; in_data = 8'h00; in_last = 1'b0; credit_ret = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_vld", 32'(out_vld), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_keep", 32'(out_keep), 32'd0);
        chk("reset_credit", 32'(credit_cnt), 32'd4);
        chk("reset_cred_err", 32'(cred_err), 32'd0);
        chk("reset_in_rdy", 32'(in_rdy), 32'd1);

        // Full word
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        push(32'h44332211, 4'hF);
        chk("full_no_early_vld", 32'(out_vld), 32'd0);
        idle();
        chk("full_vld", 32'(out_vld), 32'd1);
        chk("full_credit", 32'(credit_cnt), 32'd3);
        idle();
        chk("full_pulse", 32'(out_vld), 32'd0);
        chk("full_hold", out_data, 32'h44332211);

        // Partial word, next beat back in lane 0
        step(1, 8'hAA, 0, 0);
        step(1, 8'hBB, 1, 0);
        push(32'h0000BBAA, 4'b0011);
        step(1, 8'h01, 0, 0);
        chk("partial_vld", 32'(out_vld), 32'd1);
        chk("partial_credit", 32'(credit_cnt), 32'd2);
        step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0);
        step(1, 8'h04, 0, 0);
        push(32'h04030201, 4'hF);
        idle();
        chk("after_partial_credit", 32'(credit_cnt), 32'd1);

        // Credit exhaustion
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1, 8'(k + 1), 1'b0, 1'b0);
            if (k % 4 == 3 && k < 16)
                push({8'(k + 1), 8'(k), 8'(k - 1), 8'(k - 2)}, 4'hF);
        end
        idle();
        chk("exh_in_rdy", 32'(in_rdy), 32'd0);
        chk("exh_credit", 32'(credit_cnt), 32'd0);
        chk("exh_no_vld", 32'(out_vld), 32'd0);
        step(1, 8'hEE, 0, 0);
        step(1, 8'hEE, 1, 0);
        chk("wait_in_rdy", 32'(in_rdy), 32'd0);
        step(0, 8'h00, 0, 1);
        push(32'h14131211, 4'hF);
        idle();
        chk("wait_emit_vld", 32'(out_vld), 32'd1);
        chk("wait_emit_credit", 32'(credit_cnt), 32'd0);
        chk("wait_emit_in_rdy", 32'(in_rdy), 32'd1);

        // Simultaneous return and consume
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        idle();
        chk("sim_pre_credit", 32'(credit_cnt), 32'd2);
        step(1, 8'hDE, 0, 0);
        step(1, 8'hAD, 0, 0);
        step(1, 8'hBE, 0, 0);
        step(1, 8'hEF, 0, 1);
        push(32'hEFBEADDE, 4'hF);
        idle();
        chk("sim_vld", 32'(out_vld), 32'd1);
        chk("sim_credit", 32'(credit_cnt), 32'd2);

        // Single-lane word
        step(1, 8'h5A, 1, 0);
        push(32'h0000005A, 4'b0001);
        idle();
        chk("single_credit", 32'(credit_cnt), 32'd1);

        // Over-return
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        idle();
        chk("over_pre_credit", 32'(credit_cnt), 32'd4);
        chk("over_pre_err", 32'(cred_err), 32'd0);
        step(0, 8'h00, 0, 1);
        idle();
        chk("over_credit", 32'(credit_cnt), 32'd4);
        chk("over_err", 32'(cred_err), 32'd1);
        repeat (3) idle();
        chk("over_err_sticky", 32'(cred_err), 32'd1);

        // Reset mid-word
        step(1, 8'h55, 0, 0);
        step(1, 8'h66, 0, 0);
        do_reset();
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0);
        step(1, 8'h04, 0, 0);
        push(32'h04030201, 4'hF);
        idle();
        chk("post_rst_vld", 32'(out_vld), 32'd1);
        chk("post_rst_credit", 32'(credit_cnt), 32'd3);
        idle();
        idle();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
